// File: rtl/controlador_alvo_posicao_pkg.sv
// ============================================================================
// Package : controlador_alvo_posicao_pkg
// Purpose : Shared constants and state encoding for the position-target
//           initiator and the 1..5 ring counter it controls.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package controlador_alvo_posicao_pkg;

    // Legal positions of the ring counter and its length
    localparam logic [2:0] POS_MIN  = 3'd1;
    localparam logic [2:0] POS_MAX  = 3'd5;
    localparam int         RING_LEN = 5;

    // State encoding, shared with the command FSM and the bench
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERRO  = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CHECK = ST_CHECK,
        LOAD  = ST_LOAD,
        STEP  = ST_STEP,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE,
        ERRO  = ST_ERRO
    } estado_t;

    // True when p is a position the counter can legally hold
    function automatic logic posicao_valida(input logic [2:0] p);
        return (p >= POS_MIN) && (p <= POS_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_alvo_posicao_temporizador_passo.sv
// ============================================================================
// Module  : temporizador_passo
// Purpose : STEP_WAIT down-counter; start loads it, fim pulses for one cycle
//           during the last waiting cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_passo
    import controlador_alvo_posicao_pkg::*;
#(
    parameter int STEP_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic fim
);

    localparam int CW = $clog2(STEP_WAIT + 1);

    logic [CW-1:0] conta;

    // Load on start, then count down to zero and park there
    always_ff @(posedge clock) begin
        if (reset) begin
            conta <= '0;
        end else if (start) begin
            conta <= CW'(STEP_WAIT);
        end else if (conta != '0) begin
            conta <= conta - CW'(1);
        end
    end

    // High in the final cycle of the wait so the FSM leaves exactly on time
    assign fim = (conta == CW'(1));

endmodule

`default_nettype wire

// File: rtl/controlador_alvo_posicao.sv
// ============================================================================
// Module  : controlador_alvo_posicao
// Purpose : Drives a 1..5 wrapping up/down counter to a requested target by
//           the shortest path, with paced step pulses and done/error report.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_alvo_posicao
    import controlador_alvo_posicao_pkg::*;
#(
    parameter int STEP_WAIT  = 4,
    parameter int MAX_PASSOS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [2:0] alvo,
    input  logic [2:0] pos,
    output logic       enp,
    output logic       soma,
    output logic       sub,
    output logic       ld_n,
    output logic [2:0] D,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro
);

    localparam int PW = $clog2(MAX_PASSOS + 1);

    estado_t       estado;
    logic [2:0]    alvo_r;
    logic [PW-1:0] passos;
    logic          fim_espera;
    logic          inicia_espera;
    logic [3:0]    dif_bruta;
    logic [3:0]    d_up;
    logic          sobe;

    // Distance going up around the ring, folded into 1..4 (only used when
    // pos is legal and differs from the target)
    assign dif_bruta = {1'b0, alvo_r} + 4'(RING_LEN) - {1'b0, pos};
    assign d_up      = (dif_bruta >= 4'(RING_LEN)) ? (dif_bruta - 4'(RING_LEN)) : dif_bruta;
    assign sobe      = (d_up <= 4'd2);

    // Every LOAD or STEP pulse is followed by a fixed settling wait
    assign inicia_espera = (estado == LOAD) || (estado == STEP);

    temporizador_passo #(
        .STEP_WAIT (STEP_WAIT)
    ) u_temporizador (
        .clock (clock),
        .reset (reset),
        .start (inicia_espera),
        .fim   (fim_espera)
    );

    // Control FSM with registered strobes; outputs reflect the state they belong to
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= IDLE;
            alvo_r  <= '0;
            passos  <= '0;
            enp     <= 1'b0;
            soma    <= 1'b0;
            sub     <= 1'b0;
            ld_n    <= 1'b1;
            D       <= 3'b000;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
        end else begin
            enp    <= 1'b0;
            soma   <= 1'b0;
            sub    <= 1'b0;
            ld_n   <= 1'b1;
            D      <= 3'b000;
            pronto <= 1'b0;
            erro   <= 1'b0;
            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        if (posicao_valida(alvo)) begin
                            alvo_r  <= alvo;
                            passos  <= '0;
                            ocupado <= 1'b1;
                            estado  <= CHECK;
                        end else begin
                            erro <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Reaching the target on the last allowed pulse is success;
                    // the limit only stops a request that would need another pulse
                    if (posicao_valida(pos) && (pos == alvo_r)) begin
                        pronto <= 1'b1;
                        estado <= DONE;
                    end else if (passos == PW'(MAX_PASSOS)) begin
                        erro   <= 1'b1;
                        estado <= ERRO;
                    end else if (!posicao_valida(pos)) begin
                        ld_n   <= 1'b0;
                        D      <= POS_MIN;
                        estado <= LOAD;
                    end else begin
                        enp    <= 1'b1;
                        soma   <= sobe;
                        sub    <= !sobe;
                        estado <= STEP;
                    end
                end
                LOAD, STEP: begin
                    passos <= passos + PW'(1);
                    estado <= WAIT;
                end
                WAIT: begin
                    if (fim_espera) begin
                        estado <= CHECK;
                    end
                end
                DONE, ERRO: begin
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controlador_alvo_posicao.sv
// ============================================================================
// Module  : tb_controlador_alvo_posicao
// Purpose : Directed bench with a behavioural 1..5 ring counter model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_alvo_posicao;

    localparam int STEP_WAIT  = 4;
    localparam int MAX_PASSOS = 3;
    localparam int ESPACO     = 1 + STEP_WAIT + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [2:0] alvo;
    logic [2:0] mpos;
    logic       enp, soma, sub, ld_n, ocupado, pronto, erro;
    logic [2:0] D;

    logic       set_req;
    logic [2:0] set_val;
    logic       congelado;

    int checks = 0;
    int errors = 0;

    int ciclo = 0;
    int n_soma = 0, n_sub = 0, n_ld = 0, n_pronto = 0, n_erro = 0, n_enp = 0;
    int n_ld_d_ruim = 0, n_viol = 0;
    int soma_ant = 0, soma_ult = 0;

    controlador_alvo_posicao #(
        .STEP_WAIT  (STEP_WAIT),
        .MAX_PASSOS (MAX_PASSOS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .iniciar (iniciar),
        .alvo    (alvo),
        .pos     (mpos),
        .enp     (enp),
        .soma    (soma),
        .sub     (sub),
        .ld_n    (ld_n),
        .D       (D),
        .ocupado (ocupado),
        .pronto  (pronto),
        .erro    (erro)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    // Ring counter model: load beats count, wraps 5->1 and 1->5
    always @(posedge clock) begin
        if (set_req) begin
            mpos <= set_val;
        end else if (!congelado) begin
            if (!ld_n) begin
                mpos <= D;
            end else if (enp) begin
                if (soma)     mpos <= (mpos == 3'd5) ? 3'd1 : mpos + 3'd1;
                else if (sub) mpos <= (mpos == 3'd1) ? 3'd5 : mpos - 3'd1;
            end
        end
    end

    // Pulse counters and invariant watch, sampled mid-cycle
    always @(negedge clock) begin
        if (soma) begin
            n_soma   = n_soma + 1;
            soma_ant = soma_ult;
            soma_ult = ciclo;
        end
        if (sub)    n_sub    = n_sub + 1;
        if (enp)    n_enp    = n_enp + 1;
        if (pronto) n_pronto = n_pronto + 1;
        if (erro)   n_erro   = n_erro + 1;
        if (!ld_n) begin
            n_ld = n_ld + 1;
            if (D !== 3'd1) n_ld_d_ruim = n_ld_d_ruim + 1;
        end
        if ((soma && sub) || (enp && !ld_n) || (enp && !(soma ^ sub)) || ((soma || sub) && !enp))
            n_viol = n_viol + 1;
    end

    task automatic set_pos(input logic [2:0] v);
        @(negedge clock);
        set_req = 1'b1;
        set_val = v;
        @(negedge clock);
        set_req = 1'b0;
    endtask

    task automatic start_req(input logic [2:0] a);
        @(negedge clock);
        iniciar = 1'b1;
        alvo    = a;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Waits for pronto or erro, then one more cycle so the counters are settled
    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pronto || erro) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({enp, soma, sub, ld_n, D, ocupado, pronto, erro} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got %b want %b", {enp, soma, sub, ld_n, D, ocupado, pronto, erro}, 10'b0001000000);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_then_steps();
        int s0, l0, p0, e0;
        bit ok;
        set_pos(3'd0);
        s0 = n_soma; l0 = n_ld; p0 = n_pronto; e0 = n_erro;
        start_req(3'd3);
        wait_end(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_timeout got 0 want 1"); end
        checks++;
        if (n_ld - l0 != 1 || n_ld_d_ruim != 0) begin
            errors++; $display("FAIL load_pulse got %0d (bad D %0d) want 1 (0)", n_ld - l0, n_ld_d_ruim);
        end
        checks++;
        if (n_soma - s0 != 2) begin errors++; $display("FAIL load_soma_count got %0d want 2", n_soma - s0); end
        checks++;
        if (soma_ult - soma_ant != ESPACO) begin
            errors++; $display("FAIL soma_spacing got %0d want %0d", soma_ult - soma_ant, ESPACO);
        end
        checks++;
        if (n_pronto - p0 != 1 || n_erro - e0 != 0 || mpos !== 3'd3) begin
            errors++; $display("FAIL load_result got pronto %0d erro %0d pos %0d want 1 0 3", n_pronto - p0, n_erro - e0, mpos);
        end
    endtask

    task automatic test_wrap_down();
        int s0, b0, p0;
        bit ok;
        set_pos(3'd1);
        s0 = n_soma; b0 = n_sub; p0 = n_pronto;
        start_req(3'd5);
        wait_end(ok);
        checks++;
        if (!ok || n_sub - b0 != 1 || n_soma - s0 != 0 || n_pronto - p0 != 1 || mpos !== 3'd5) begin
            errors++;
            $display("FAIL wrap_down got ok %0d sub %0d soma %0d pronto %0d pos %0d want 1 1 0 1 5", ok, n_sub - b0, n_soma - s0, n_pronto - p0, mpos);
        end
    endtask

    task automatic test_wrap_up_and_latency();
        int s0, b0, p0, en0;
        bit ok;
        set_pos(3'd4);
        s0 = n_soma; b0 = n_sub; p0 = n_pronto;
        start_req(3'd1);
        wait_end(ok);
        checks++;
        if (!ok || n_soma - s0 != 2 || n_sub - b0 != 0 || n_pronto - p0 != 1 || mpos !== 3'd1) begin
            errors++;
            $display("FAIL wrap_up got ok %0d soma %0d sub %0d pronto %0d pos %0d want 1 2 0 1 1", ok, n_soma - s0, n_sub - b0, n_pronto - p0, mpos);
        end
        // Already at target: CHECK one cycle after acceptance, pronto the next
        set_pos(3'd2);
        en0 = n_enp; b0 = n_ld;
        @(negedge clock);
        iniciar = 1'b1;
        alvo    = 3'd2;
        @(negedge clock);
        iniciar = 1'b0;
        checks++;
        if (ocupado !== 1'b1 || pronto !== 1'b0) begin
            errors++; $display("FAIL latency_n1 got ocupado %b pronto %b want 1 0", ocupado, pronto);
        end
        @(negedge clock);
        checks++;
        if (pronto !== 1'b1) begin errors++; $display("FAIL latency_n2 got pronto %b want 1", pronto); end
        @(negedge clock);
        checks++;
        if (n_enp - en0 != 0 || n_ld - b0 != 0) begin
            errors++; $display("FAIL latency_strobes got enp %0d ld %0d want 0 0", n_enp - en0, n_ld - b0);
        end
    endtask

    task automatic test_illegal_target();
        logic [2:0] ruins [2];
        int en0, l0;
        ruins[0] = 3'd0;
        ruins[1] = 3'd6;
        en0 = n_enp; l0 = n_ld;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            iniciar = 1'b1;
            alvo    = ruins[i];
            @(negedge clock);
            iniciar = 1'b0;
            checks++;
            if (erro !== 1'b1 || ocupado !== 1'b0) begin
                errors++; $display("FAIL illegal_%0d got erro %b ocupado %b want 1 0", ruins[i], erro, ocupado);
            end
            @(negedge clock);
            checks++;
            if (erro !== 1'b0 || ocupado !== 1'b0) begin
                errors++; $display("FAIL illegal_after_%0d got erro %b ocupado %b want 0 0", ruins[i], erro, ocupado);
            end
        end
        checks++;
        if (n_enp - en0 != 0 || n_ld - l0 != 0) begin
            errors++; $display("FAIL illegal_strobes got enp %0d ld %0d want 0 0", n_enp - en0, n_ld - l0);
        end
    endtask

    task automatic test_step_limit();
        int s0, p0, e0;
        bit ok;
        set_pos(3'd2);
        congelado = 1'b1;
        s0 = n_soma; p0 = n_pronto; e0 = n_erro;
        start_req(3'd4);
        wait_end(ok);
        checks++;
        if (!ok || n_soma - s0 != MAX_PASSOS || n_erro - e0 != 1 || n_pronto - p0 != 0) begin
            errors++;
            $display("FAIL step_limit got ok %0d soma %0d erro %0d pronto %0d want 1 3 1 0", ok, n_soma - s0, n_erro - e0, n_pronto - p0);
        end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL step_limit_ocupado got %b want 0", ocupado); end
        congelado = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int en0;
        set_pos(3'd1);
        start_req(3'd3);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (enp) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_mid_no_step got 0 want 1"); end
        @(negedge clock);        // WAIT cycle 1
        @(negedge clock);        // WAIT cycle 2: reset and a request together
        reset   = 1'b1;
        iniciar = 1'b1;
        alvo    = 3'd2;
        @(negedge clock);
        checks++;
        if ({enp, soma, sub, ld_n, D, ocupado, pronto, erro} !== 10'b0001000000) begin
            errors++; $display("FAIL reset_mid got %b want %b", {enp, soma, sub, ld_n, D, ocupado, pronto, erro}, 10'b0001000000);
        end
        reset   = 1'b0;
        iniciar = 1'b0;
        en0 = n_enp;
        repeat (10) @(negedge clock);
        checks++;
        if (ocupado !== 1'b0 || n_enp - en0 != 0) begin
            errors++; $display("FAIL reset_mid_idle got ocupado %b enp %0d want 0 0", ocupado, n_enp - en0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, p0;
        bit ok;
        set_pos(3'd1);
        b0 = n_sub; p0 = n_pronto;
        start_req(3'd3);
        @(negedge clock);
        iniciar = 1'b1;          // must be ignored while busy
        alvo    = 3'd5;
        @(negedge clock);
        iniciar = 1'b0;
        alvo    = 3'd4;
        wait_end(ok);
        checks++;
        if (!ok || mpos !== 3'd3 || n_sub - b0 != 0 || n_pronto - p0 != 1) begin
            errors++;
            $display("FAIL busy_ignore got ok %0d pos %0d sub %0d pronto %0d want 1 3 0 1", ok, mpos, n_sub - b0, n_pronto - p0);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle got %b want 0", ocupado); end
        checks++;
        if (n_viol != 0) begin errors++; $display("FAIL strobe_invariants got %0d want 0", n_viol); end
    endtask

    initial begin
        reset     = 1'b1;
        iniciar   = 1'b0;
        alvo      = 3'd0;
        set_req   = 1'b0;
        set_val   = 3'd0;
        congelado = 1'b0;
        test_reset();
        test_load_then_steps();
        test_wrap_down();
        test_wrap_up_and_latency();
        test_illegal_target();
        test_step_limit();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
